// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the APB UART: transmit FSM state encoding, field
// positions inside the 5-bit frame configuration word, frame-length helpers
// and the register map used by the APB register block.
// ---------------------------------------------------------------------------
package uart_pkg;

  // Transmit FSM states, in the order a frame walks through them.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP1,
    ST_STOP2
  } tx_state_t;

  // Field positions inside cfg[4:0].
  localparam int DBITS_LSB    = 0;
  localparam int STOP_BIT     = 2;
  localparam int PAR_EN_BIT   = 3;
  localparam int PAR_TYPE_BIT = 4;

  // Register map shared with the APB register block.
  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_STT    = 8'h04;
  localparam logic [7:0] ADDR_TXDATA = 8'h08;
  localparam logic [7:0] ADDR_CFG    = 8'h0C;
  localparam logic [7:0] ADDR_RXDATA = 8'h10;

  // Number of data bits in a frame: 00 -> 5 ... 11 -> 8.
  function automatic logic [3:0] data_len(input logic [1:0] dbits);
    return 4'd5 + {2'b00, dbits};
  endfunction

  // Mask selecting the data bits that are actually transmitted.
  function automatic logic [7:0] data_mask(input logic [1:0] dbits);
    return 8'hFF >> (2'd3 - dbits);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period timer shared by the UART transmitter and receiver. Counts
// 0..BAUD_DIV-1 while enabled and emits a one-cycle bit_tick on the terminal
// count, after which the count restarts from 0.
//
// Ports:
//   pclk      clock
//   presetn   asynchronous active-low reset
//   clear     restart the bit period (frame accept)
//   enable    count while a frame is in progress
//   bit_tick  high during the last cycle of each bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int BAUD_DIV = 868
) (
  input  logic pclk,
  input  logic presetn,
  input  logic clear,
  input  logic enable,
  output logic bit_tick
);

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(BAUD_DIV - 1);

  logic [CW-1:0] baud_cnt;

  assign bit_tick = enable && (baud_cnt == TERM);

  // Free-running divider while enabled; a clear or terminal count restarts it
  // so every bit period is exactly BAUD_DIV cycles long.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      baud_cnt <= '0;
    end else if (clear || bit_tick) begin
      baud_cnt <= '0;
    end else if (enable) begin
      baud_cnt <= baud_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// ---------------------------------------------------------------------------
// uart_tx_engine
// Serial transmit engine of the APB UART. A rising edge on start_tx while
// idle latches tx_data/cfg into shadow registers and sends one frame:
// start bit, 5-8 data bits LSB first, optional parity, 1 or 2 stop bits.
//
// Ports:
//   pclk      clock
//   presetn   asynchronous active-low reset
//   tx_data   byte to send (bits above the configured length ignored)
//   start_tx  start request level; its rising edge triggers a frame
//   cfg       [1:0] data bits, [2] two stop bits, [3] parity enable,
//             [4] parity type (0 even, 1 odd)
//   tx        serial line, idle high
//   tx_busy   frame in progress
//   tx_done   set at frame end, cleared when the next frame is accepted
// ---------------------------------------------------------------------------
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = 868
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic [7:0] tx_data,
  input  logic       start_tx,
  input  logic [4:0] cfg,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  tx_state_t  state;
  logic       start_q;
  logic [7:0] shift_reg;
  logic [1:0] dbits_q;
  logic       stop2_q;
  logic       par_en_q;
  logic       parity_q;
  logic [2:0] bit_cnt;
  logic       bit_tick;
  logic       accept;
  logic       last_bit;

  assign accept   = start_tx && !start_q && (state == ST_IDLE);
  assign last_bit = (bit_cnt == 3'(data_len(dbits_q) - 4'd1));

  uart_baud_gen #(
    .BAUD_DIV (BAUD_DIV)
  ) u_baud_gen (
    .pclk     (pclk),
    .presetn  (presetn),
    .clear    (accept),
    .enable   (state != ST_IDLE),
    .bit_tick (bit_tick)
  );

  // Delayed copy of the start request for rising-edge detection, so a level
  // held high never retriggers.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start_tx;
    end
  end

  // Frame sequencer. tx is registered and is always loaded with the level of
  // the state being entered, so the line changes on the same edge as the
  // state. Parity is computed once at accept from the live inputs.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      tx        <= 1'b1;
      tx_busy   <= 1'b0;
      tx_done   <= 1'b0;
      shift_reg <= '0;
      dbits_q   <= '0;
      stop2_q   <= 1'b0;
      par_en_q  <= 1'b0;
      parity_q  <= 1'b0;
      bit_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            shift_reg <= tx_data;
            dbits_q   <= cfg[DBITS_LSB +: 2];
            stop2_q   <= cfg[STOP_BIT];
            par_en_q  <= cfg[PAR_EN_BIT];
            parity_q  <= (^(tx_data & data_mask(cfg[DBITS_LSB +: 2])))
                         ^ cfg[PAR_TYPE_BIT];
            state     <= ST_START;
            tx        <= 1'b0;
            tx_busy   <= 1'b1;
            tx_done   <= 1'b0;
          end
        end
        ST_START: begin
          if (bit_tick) begin
            state   <= ST_DATA;
            bit_cnt <= '0;
            tx      <= shift_reg[0];
          end
        end
        ST_DATA: begin
          if (bit_tick) begin
            if (last_bit) begin
              if (par_en_q) begin
                state <= ST_PARITY;
                tx    <= parity_q;
              end else begin
                state <= ST_STOP1;
                tx    <= 1'b1;
              end
            end else begin
              bit_cnt   <= bit_cnt + 3'd1;
              shift_reg <= shift_reg >> 1;
              tx        <= shift_reg[1];
            end
          end
        end
        ST_PARITY: begin
          if (bit_tick) begin
            state <= ST_STOP1;
            tx    <= 1'b1;
          end
        end
        ST_STOP1: begin
          if (bit_tick) begin
            if (stop2_q) begin
              state <= ST_STOP2;
            end else begin
              state   <= ST_IDLE;
              tx_busy <= 1'b0;
              tx_done <= 1'b1;
            end
          end
        end
        ST_STOP2: begin
          if (bit_tick) begin
            state   <= ST_IDLE;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          tx      <= 1'b1;
          tx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_engine.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_engine
// Scoreboard bench for uart_tx_engine with BAUD_DIV=4. The stimulus thread
// pushes the expected line waveform of each frame (one character per bit,
// in transmit order) into a queue; the monitor thread pops one entry whenever
// tx_busy rises and checks every cycle of the frame plus the end status.
// ---------------------------------------------------------------------------
module tb_uart_tx_engine;

  localparam int BAUD = 4;

  logic       pclk = 1'b0;
  logic       presetn;
  logic [7:0] tx_data;
  logic       start_tx;
  logic [4:0] cfg;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int    checks = 0;
  int    errors = 0;
  string exp_q[$];
  bit    mon_ignore = 1'b0;
  bit    mon_active = 1'b0;

  uart_tx_engine #(
    .BAUD_DIV (BAUD)
  ) dut (
    .pclk     (pclk),
    .presetn  (presetn),
    .tx_data  (tx_data),
    .start_tx (start_tx),
    .cfg      (cfg),
    .tx       (tx),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  // 10 ns clock.
  always #5 pclk = ~pclk;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, want);
    end
  endtask

  // Called at a negedge: loads the inputs, raises start_tx for one cycle and
  // returns at the negedge right after the accepting clock edge.
  task automatic applyStimulus(input logic [7:0] data, input logic [4:0] c,
                               input string want_bits, input bit expect_frame);
    tx_data  = data;
    cfg      = c;
    if (expect_frame) exp_q.push_back(want_bits);
    start_tx = 1'b1;
    @(posedge pclk);
    @(negedge pclk);
    start_tx = 1'b0;
  endtask

  // One complete frame followed by a single idle cycle.
  task automatic runFrame(input logic [7:0] data, input logic [4:0] c,
                          input string want_bits);
    applyStimulus(data, c, want_bits, 1'b1);
    repeat (want_bits.len() * BAUD + 1) @(negedge pclk);
  endtask

  // Monitor: when a frame starts, compare each bit period against the next
  // queued waveform, then check the status flags after the last stop bit.
  int    frame_no = 0;
  int    bad_tx;
  int    bad_busy;
  int    drain;
  logic  act_tx;
  logic  want_tx;
  string want_bits;

  initial begin
    forever begin
      @(negedge pclk);
      if (presetn === 1'b1 && tx_busy === 1'b1) begin
        mon_active = 1'b1;
        if (mon_ignore || exp_q.size() == 0) begin
          if (!mon_ignore) checkOutput("unexpected_frame", 32'd1, 32'd0);
          drain = 0;
          while (tx_busy === 1'b1 && drain < 500) begin
            @(negedge pclk);
            drain++;
          end
        end else begin
          want_bits = exp_q.pop_front();
          frame_no++;
          checkOutput($sformatf("frame%0d_done_low_at_start", frame_no),
                      tx_done, 0);
          for (int b = 0; b < want_bits.len(); b++) begin
            want_tx  = (want_bits.getc(b) == 8'h31);
            act_tx   = want_tx;
            bad_tx   = 0;
            bad_busy = 0;
            for (int c = 0; c < BAUD; c++) begin
              if (b != 0 || c != 0) @(negedge pclk);
              if (tx !== want_tx) begin
                if (bad_tx == 0) act_tx = tx;
                bad_tx++;
              end
              if (tx_busy !== 1'b1) bad_busy++;
            end
            checkOutput($sformatf("frame%0d_bit%0d_tx", frame_no, b),
                        act_tx, want_tx);
            checkOutput($sformatf("frame%0d_bit%0d_busy_lowcycles", frame_no, b),
                        bad_busy, 0);
          end
          @(negedge pclk);
          checkOutput($sformatf("frame%0d_end_busy", frame_no), tx_busy, 0);
          checkOutput($sformatf("frame%0d_end_done", frame_no), tx_done, 1);
          checkOutput($sformatf("frame%0d_end_tx", frame_no), tx, 1);
        end
        mon_active = 1'b0;
      end
    end
  end

  // Directed stimulus sequence.
  int wait_cnt;

  initial begin
    presetn  = 1'b0;
    start_tx = 1'b0;
    tx_data  = 8'h00;
    cfg      = 5'b00000;
    repeat (3) @(negedge pclk);
    checkOutput("reset_tx", tx, 1);
    checkOutput("reset_busy", tx_busy, 0);
    checkOutput("reset_done", tx_done, 0);
    presetn = 1'b1;
    @(negedge pclk);
    checkOutput("idle_tx", tx, 1);

    // 8N1, 0xA5
    runFrame(8'hA5, 5'b00011, "0101001011");
    // 8 bits, odd parity, 2 stop, 0x0F -> parity 1
    runFrame(8'h0F, 5'b11111, "011110000111");
    // same with even parity -> parity 0
    runFrame(8'h0F, 5'b01111, "011110000011");
    // 5 bits of 0xFF: upper bits never reach the line
    runFrame(8'hFF, 5'b00000, "0111111");
    // 7 bits of 0x80: bit 7 never reaches the line
    runFrame(8'h80, 5'b10010, "000000001");
    // 6 bits, even parity, 2 stop, 0x2C
    runFrame(8'h2C, 5'b01101, "0001101111");

    // start_tx held high for three frame lengths; inputs change mid-frame
    tx_data  = 8'h3C;
    cfg      = 5'b00011;
    exp_q.push_back("0001111001");
    start_tx = 1'b1;
    @(posedge pclk);
    repeat (2 * BAUD + 1) @(negedge pclk);
    tx_data  = 8'hC3;
    cfg      = 5'b11100;
    repeat (3 * 10 * BAUD) @(negedge pclk);
    start_tx = 1'b0;
    repeat (4) @(negedge pclk);

    // a second rising edge mid-frame is dropped
    applyStimulus(8'h2C, 5'b01101, "0001101111", 1'b1);
    repeat (5) @(negedge pclk);
    start_tx = 1'b1;
    @(negedge pclk);
    start_tx = 1'b0;
    tx_data  = 8'h00;
    cfg      = 5'b00000;
    repeat (2 * 10 * BAUD) @(negedge pclk);

    // start edge sampled at edge k+F is dropped
    applyStimulus(8'hA5, 5'b00011, "0101001011", 1'b1);
    repeat (10 * BAUD - 1) @(negedge pclk);
    start_tx = 1'b1;
    @(negedge pclk);
    start_tx = 1'b0;
    checkOutput("late_start_dropped_busy", tx_busy, 0);
    repeat (2 * 10 * BAUD) @(negedge pclk);

    // start edge sampled at edge k+F+1 is accepted and clears tx_done
    applyStimulus(8'h0F, 5'b01111, "011110000011", 1'b1);
    repeat (12 * BAUD) @(negedge pclk);
    applyStimulus(8'hFF, 5'b00000, "0111111", 1'b1);
    checkOutput("done_falls_on_accept", tx_done, 0);
    checkOutput("busy_on_back_to_back", tx_busy, 1);
    repeat (7 * BAUD + 1) @(negedge pclk);

    // asynchronous reset in the middle of DATA (line would be 0 here)
    mon_ignore = 1'b1;
    applyStimulus(8'hA5, 5'b00011, "", 1'b0);
    repeat (9) @(negedge pclk);
    checkOutput("pre_abort_tx_low", tx, 0);
    #2 presetn = 1'b0;
    #1;
    checkOutput("abort_tx", tx, 1);
    checkOutput("abort_busy", tx_busy, 0);
    checkOutput("abort_done", tx_done, 0);
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    repeat (3) @(negedge pclk);
    mon_ignore = 1'b0;
    checkOutput("post_abort_idle_tx", tx, 1);
    runFrame(8'h5A, 5'b00011, "0010110101");

    // let the monitor drain the queue
    wait_cnt = 0;
    while ((exp_q.size() != 0 || mon_active) && wait_cnt < 1000) begin
      @(negedge pclk);
      wait_cnt++;
    end
    checkOutput("frames_pending", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
